// File: rtl/keypad_array_scanner.sv
// Multi-pad matrix keypad scanner: one shared row-scan FSM, per-pad frame debouncing,
// lowest-index key encoding and a round-robin arbitrated event stream with overflow flags.
module keypad_array_scanner #(
    parameter int NUM_PADS       = 2,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 25000,
    parameter int DEBOUNCE_SCANS = 4,
    localparam int KI = $clog2(ROWS * COLS),
    localparam int KW = KI + 1,
    localparam int PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_PADS*COLS-1:0] cols,
    output logic [NUM_PADS*ROWS-1:0] rows,
    output logic [NUM_PADS*KW-1:0]   keycode,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [PW-1:0]            evt_pad,
    output logic                     evt_press,
    output logic [KI-1:0]            evt_key,
    output logic [NUM_PADS-1:0]      overflow,
    output logic [1:0]               dbg_state
);

    localparam int NK = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_SAMPLE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [SW-1:0]   settle_q, settle_d;

    logic [NK-1:0]   raw_q    [NUM_PADS];
    logic [NK-1:0]   last_q   [NUM_PADS];
    logic [NK-1:0]   stable_q [NUM_PADS];
    logic [CW-1:0]   cnt_q    [NUM_PADS];
    logic [CW-1:0]   cnt_nxt  [NUM_PADS];
    logic [NUM_PADS-1:0] load;

    logic [KW-1:0]   kc_now    [NUM_PADS];
    logic [KW-1:0]   kc_prev_q [NUM_PADS];
    logic [NUM_PADS-1:0] ev, ev_press;
    logic [KI-1:0]   ev_key    [NUM_PADS];

    logic [NUM_PADS-1:0] slot_v_q, slot_v_d, slot_press_q;
    logic [KI-1:0]   slot_key_q [NUM_PADS];
    logic            cur_v_q;
    logic [PW-1:0]   cur_pad_q, rr_q, pick, rr_nxt;
    logic            pick_v, hs;

    // ---------------- scan FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_SETTLE;
            row_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
        end
    end

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        case (state_q)
            S_SETTLE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = S_COMMIT;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = S_SETTLE;
                end
            end
            S_COMMIT: begin
                row_d   = '0;
                state_d = S_SETTLE;
            end
            default: begin
                row_d    = '0;
                settle_d = '0;
                state_d  = S_SETTLE;
            end
        endcase
    end

    // ---------------- scan FSM: outputs ----------------
    // Rows float high the instant reset asserts, not one clock later.
    always_comb begin
        rows      = '1;
        dbg_state = state_q;
        if (!rst && state_q != S_COMMIT) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                rows[p*ROWS +: ROWS] = ~(ROWS'(1) << row_q);
            end
        end
    end

    // cnt counts repeats beyond the first sighting of a frame, so N identical
    // consecutive frames are reached when the updated count equals N-1.
    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            cnt_nxt[p] = '0;
            if (raw_q[p] == last_q[p]) begin
                cnt_nxt[p] = (cnt_q[p] == CW'(DEBOUNCE_SCANS)) ? cnt_q[p] : cnt_q[p] + 1'b1;
            end
            load[p] = (int'(cnt_nxt[p]) + 1 >= DEBOUNCE_SCANS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                raw_q[p]    <= '0;
                last_q[p]   <= '0;
                stable_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
        end else if (state_q == S_SAMPLE) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                raw_q[p][int'(row_q)*COLS +: COLS] <= ~cols[p*COLS +: COLS];
            end
        end else if (state_q == S_COMMIT) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                cnt_q[p]  <= cnt_nxt[p];
                last_q[p] <= raw_q[p];
                if (load[p]) stable_q[p] <= raw_q[p];
            end
        end
    end

    // ---------------- key encoding and change detection ----------------
    always_comb begin
        keycode = '0;
        for (int p = 0; p < NUM_PADS; p++) begin
            kc_now[p] = '0;
            for (int k = NK - 1; k >= 0; k--) begin
                if (stable_q[p][k]) kc_now[p] = {1'b1, KI'(k)};
            end
            keycode[p*KW +: KW] = kc_now[p];
            ev[p]       = (kc_now[p] != kc_prev_q[p]);
            ev_press[p] = kc_now[p][KW-1];
            ev_key[p]   = ev_press[p] ? kc_now[p][KI-1:0] : kc_prev_q[p][KI-1:0];
        end
    end

    // ---------------- event slots and arbitration ----------------
    // Event stream: a transfer happens on a clock edge where evt_valid && evt_ready;
    // evt_pad stays fixed until then, and the payload is the pad's pending slot
    // (it is replaced only if that pad produces a newer event meanwhile).
    assign hs = cur_v_q && evt_ready;

    always_comb begin
        int idx;
        idx    = 0;
        pick_v = 1'b0;
        pick   = cur_pad_q;
        for (int p = 0; p < NUM_PADS; p++) begin
            slot_v_d[p] = slot_v_q[p];
            if (hs && cur_pad_q == PW'(p)) slot_v_d[p] = 1'b0;
            if (ev[p]) slot_v_d[p] = 1'b1;
        end
        for (int i = 0; i < NUM_PADS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_PADS) idx = idx - NUM_PADS;
            if (!pick_v && slot_v_d[idx]) begin
                pick_v = 1'b1;
                pick   = PW'(idx);
            end
        end
        idx    = int'(pick) + 1;
        rr_nxt = (idx >= NUM_PADS) ? '0 : PW'(idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                kc_prev_q[p]  <= '0;
                slot_key_q[p] <= '0;
            end
            slot_v_q     <= '0;
            slot_press_q <= '0;
            overflow     <= '0;
            cur_v_q      <= 1'b0;
            cur_pad_q    <= '0;
            rr_q         <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            for (int p = 0; p < NUM_PADS; p++) begin
                kc_prev_q[p] <= kc_now[p];
                if (ev[p]) begin
                    slot_press_q[p] <= ev_press[p];
                    slot_key_q[p]   <= ev_key[p];
                    if (slot_v_q[p] && !(hs && cur_pad_q == PW'(p))) overflow[p] <= 1'b1;
                end
            end
            if (!cur_v_q || evt_ready) begin
                cur_v_q <= pick_v;
                if (pick_v) begin
                    cur_pad_q <= pick;
                    rr_q      <= rr_nxt;
                end
            end
        end
    end

    assign evt_valid = cur_v_q;
    assign evt_pad   = cur_pad_q;
    assign evt_press = slot_press_q[cur_pad_q];
    assign evt_key   = slot_key_q[cur_pad_q];

endmodule

// File: tb/tb_keypad_array_scanner.sv
// Bench for keypad_array_scanner: 2 pads of 4x4, 4-cycle settle, 2-frame debounce (21-cycle frame),
// with a behavioural keypad matrix and a scoreboard of expected events.
module tb_keypad_array_scanner;

    localparam int NP = 2;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam int FRAME = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cols;
    logic [7:0]  rows;
    logic [9:0]  keycode;
    logic        evt_valid;
    logic        evt_ready;
    logic [0:0]  evt_pad;
    logic        evt_press;
    logic [3:0]  evt_key;
    logic [1:0]  overflow;
    logic [1:0]  dbg_state;

    logic [15:0] keys [NP];
    logic [5:0]  exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_unexp = 0;
    int          bad_cycles = 0;
    logic        watch_quiet = 1'b0;
    logic        chk_hold = 1'b0;
    logic        prev_wait = 1'b0;
    logic [6:0]  prev_payload = '0;

    keypad_array_scanner #(
        .NUM_PADS(NP), .ROWS(NR), .COLS(NC), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .cols(cols), .rows(rows), .keycode(keycode),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_pad(evt_pad),
        .evt_press(evt_press), .evt_key(evt_key), .overflow(overflow), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = '1;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++)
                    if (!rows[p*NR+r] && keys[p][r*NC+c]) cols[p*NC+c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ev(input int pad, input logic press, input int key);
        logic [5:0] e;
        e = {pad[0], press, key[3:0]};
        return e;
    endfunction

    function automatic logic [7:0] exp_rows(input int t);
        logic [3:0] m;
        if (t == FRAME - 1) return 8'hFF;
        m = 4'b0001 << (t / 5);
        return ~{m, m};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    check("evt", {evt_pad, evt_press, evt_key}, exp_q.pop_front());
                end
            end
            if (chk_hold && prev_wait)
                check("evt_hold", {evt_valid, evt_pad, evt_press, evt_key}, prev_payload);
            prev_wait    = evt_valid && !evt_ready;
            prev_payload = {evt_valid, evt_pad, evt_press, evt_key};
            if (watch_quiet && (evt_valid || keycode != 10'd0)) bad_cycles++;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at cycle 0 (row 0 settle) of the frame following the next COMMIT.
    task automatic frame_start();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (dbg_state == 2'd2) found = 1'b1;
        end
        check("commit_seen", found, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle_key();
        frame_start();
        frame_start();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (12) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
        check("extra_events", n_unexp, 0);
    endtask

    task automatic run_from_release(input int n_cycles, input logic [9:0] kc_exp);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int t = 0; t < n_cycles; t++) begin
            if (t > 0) begin
                @(negedge clk);
                #1;
            end
            if (t < FRAME) check($sformatf("rows_t%0d", t), rows, exp_rows(t));
            if (t == 41) check("kc_before_f2", keycode, 0);
            if (t == 42) check("kc_after_f2", keycode, kc_exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rows"}, rows, 8'hFF);
        check({tag, "_keycode"}, keycode, 0);
        check({tag, "_evt_valid"}, evt_valid, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b1;
        evt_ready = 1'b1;
        keys[0] = 16'h0040;          // pad0 row1/col2 held from reset
        keys[1] = 16'h0000;
        exp_q.push_back(ev(0, 1'b1, 6));
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        run_from_release(46, 10'b00000_10110);
        drain();

        // frame length between two COMMITs
        frame_start();
        n = 1;
        while (dbg_state != 2'd2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_len", n, FRAME);

        // two keys together, then release the lower one
        frame_start();
        keys[0] = (16'h1 << 3) | (16'h1 << 9);
        exp_q.push_back(ev(0, 1'b1, 3));
        settle_key();
        check("kc_two_keys", keycode, 10'b00000_10011);
        frame_start();
        keys[0] = 16'h1 << 9;
        exp_q.push_back(ev(0, 1'b1, 9));
        settle_key();
        check("kc_key9", keycode, 10'b00000_11001);
        frame_start();
        keys[0] = 16'h0;
        exp_q.push_back(ev(0, 1'b0, 9));
        settle_key();
        check("kc_released", keycode, 0);
        drain();

        // bouncing key: contact changes every frame
        watch_quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            frame_start();
            keys[0] = (i % 2 == 0) ? 16'h0040 : 16'h0000;
        end
        frame_start();
        frame_start();
        frame_start();
        watch_quiet = 1'b0;
        check("bounce_quiet", bad_cycles, 0);
        drain();

        // two pads in the same frame, consumer stalled
        evt_ready = 1'b0;
        rst = 1'b1;
        keys[0] = 16'h1 << 1;
        keys[1] = 16'h1 << 4;
        exp_q.push_back(ev(0, 1'b1, 1));
        exp_q.push_back(ev(1, 1'b1, 4));
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset2");
        run_from_release(43, 10'b10100_10001);
        n = 0;
        while (!evt_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", evt_valid, 1);
        chk_hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        evt_ready = 1'b1;
        drain();
        frame_start();
        keys[0] = 16'h0;
        keys[1] = 16'h0;
        exp_q.push_back(ev(0, 1'b0, 1));
        exp_q.push_back(ev(1, 1'b0, 4));
        settle_key();
        drain();
        chk_hold = 1'b0;

        // three changes on pad0 while stalled: only the newest survives
        evt_ready = 1'b0;
        check("ovf_before", overflow, 0);
        frame_start();
        keys[0] = 16'h1 << 5;
        settle_key();
        frame_start();
        keys[0] = 16'h1 << 6;
        settle_key();
        frame_start();
        keys[0] = 16'h0;
        exp_q.push_back(ev(0, 1'b0, 6));
        settle_key();
        check("ovf_flag", overflow, 2'b01);
        check("ovf_payload", {evt_valid, evt_pad, evt_press, evt_key}, {1'b1, ev(0, 1'b0, 6)});
        evt_ready = 1'b1;
        drain();
        check("ovf_sticky", overflow, 2'b01);

        // reset in the middle of row 2
        frame_start();
        repeat (11) @(posedge clk);
        #1;
        check("rows_row2", rows, 8'hBB);
        rst = 1'b1;
        #1;
        reset_checks("reset_mid");
        repeat (3) @(posedge clk);
        #1;
        run_from_release(FRAME, 10'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
